fht_addr_seq: RTL and testbench

//  Parametrised FHT address sequencer. Next generation of the fixed 4-bank FHT controller.

---
 rtl/fht_addr_pkg.sv | 25 ++
 rtl/fht_delay_line.sv | 31 +++
 rtl/fht_addr_seq.sv | 162 ++++++++++++++++
 tb/tb_fht_addr_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_addr_pkg.sv
// Shared state type and address helpers for the FHT address sequencer.
package fht_addr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_t;

  // Helpers operate on up to 8-bit bank addresses.
  function automatic logic [7:0] bitrev(input logic [7:0] addr, input int unsigned width);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(width)) res[3'(int'(width) - 1 - i)] = addr[3'(i)];
    end
    return res;
  endfunction

  function automatic logic [7:0] coef_addr(input logic [7:0] cnt, input int unsigned j,
                                           input int unsigned a_bit);
    logic [7:0] mask;
    logic [7:0] res;
    mask = 8'((1 << j) - 1);
    res  = 8'((cnt & mask) << (a_bit - j));
    return res & 8'((1 << a_bit) - 1);
  endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Fixed-latency shift register with synchronous reset; DEPTH 0 degenerates to a wire.
module fht_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = ^{i_clk, i_reset};
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_data;
        for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_data = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/fht_addr_seq.sv
// Parametrised FHT address sequencer: per-bank read/write/twiddle addressing with drain and DONE.
// Define FHT_STEP_EN to pause in STEP between stages until the next iSTART.
module fht_addr_seq
  import fht_addr_pkg::*;
#(
  parameter int unsigned A_BIT  = 3,
  parameter int unsigned N_BANK = 4,
  parameter int unsigned BF_LAT = 2,
  parameter int unsigned STAGES = A_BIT + 1
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic                        iSTART,
  output logic [N_BANK*A_BIT-1:0]     oADDR_RD,
  output logic                        oRD_VALID,
  output logic [N_BANK*A_BIT-1:0]     oADDR_WR,
  output logic [A_BIT-1:0]            oADDR_COEF,
  output logic                        oWE_A,
  output logic                        oWE_B,
  output logic [$clog2(STAGES)-1:0]   oSTAGE,
  output logic                        oST_ZERO,
  output logic                        oST_LAST,
  output logic                        oRDY,
  output logic                        oDONE
);

  localparam int unsigned BANK_SIZE = 1 << A_BIT;
  localparam int unsigned SW        = $clog2(STAGES);
  localparam int unsigned DW        = N_BANK * A_BIT + 2;
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

  state_t            r_state, w_state_nxt;
  logic [A_BIT-1:0]  r_cnt, w_cnt_nxt;
  logic [SW-1:0]     r_stage, w_stage_nxt;
  logic [3:0]        r_drain, w_drain_nxt;
  logic              r_done, w_done_nxt;
  logic              w_stage_end;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_drain <= w_drain_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_drain_nxt = r_drain;
    w_done_nxt  = 1'b0;
    w_stage_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (iSTART) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == A_BIT'(BANK_SIZE - 1)) begin
          if (BF_LAT == 0) begin
            w_stage_end = 1'b1;
          end else begin
            w_state_nxt = DRAIN;
            w_drain_nxt = '0;
          end
        end
      end
      DRAIN: begin
        w_drain_nxt = r_drain + 1'b1;
        if (r_drain == 4'(BF_LAT - 1)) w_stage_end = 1'b1;
      end
      STEP: begin
        if (iSTART) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase

    // The NEXT decision costs no cycle: it is folded into the edge that ends a stage.
    if (w_stage_end) begin
      w_cnt_nxt = '0;
      if (r_stage != LAST_STAGE) begin
        w_stage_nxt = r_stage + 1'b1;
`ifdef FHT_STEP_EN
        w_state_nxt = STEP;
`else
        w_state_nxt = RUN;
`endif
      end else begin
        w_state_nxt = IDLE;
        w_stage_nxt = '0;
        w_done_nxt  = 1'b1;
      end
    end
  end

  logic                               w_rd_valid;
  logic [SW-1:0]                      w_j;
  logic [N_BANK-1:0][A_BIT-1:0]       w_rd_addr;
  logic [N_BANK-1:0][A_BIT-1:0]       w_wr_addr;
  logic [DW-1:0]                      w_dl_in, w_dl_out;
  logic                               w_wr_strobe, w_wr_parity;

  assign w_rd_valid = (r_state == RUN);
  assign w_j        = r_stage - SW'(1);

  // Odd banks read the butterfly partner of the shared counter address.
  always_comb begin
    for (int b = 0; b < int'(N_BANK); b++) begin
      w_rd_addr[b] = '0;
      if (w_rd_valid) begin
        if (r_stage == '0) w_rd_addr[b] = A_BIT'(bitrev(8'(r_cnt), A_BIT));
        else               w_rd_addr[b] = r_cnt ^ (A_BIT'(b % 2) << w_j);
      end
    end
  end

  always_comb begin
    oADDR_COEF = '0;
    if (w_rd_valid && (r_stage != '0)) begin
      oADDR_COEF = A_BIT'(coef_addr(8'(r_cnt), 32'(w_j), A_BIT));
    end
  end

  assign w_dl_in = {w_rd_addr, w_rd_valid, r_stage[0]};

  fht_delay_line #(
    .WIDTH (DW),
    .DEPTH (BF_LAT)
  ) u_delay (
    .i_clk   (iCLK),
    .i_reset (iRESET),
    .i_data  (w_dl_in),
    .o_data  (w_dl_out)
  );

  assign {w_wr_addr, w_wr_strobe, w_wr_parity} = w_dl_out;

  assign oADDR_RD  = w_rd_addr;
  assign oRD_VALID = w_rd_valid;
  assign oADDR_WR  = w_wr_addr;
  assign oWE_A     = w_wr_strobe & ~w_wr_parity;
  assign oWE_B     = w_wr_strobe & w_wr_parity;
  assign oSTAGE    = r_stage;
  assign oST_ZERO  = (r_state != IDLE) && (r_stage == '0);
  assign oST_LAST  = (r_state != IDLE) && (r_stage == LAST_STAGE);
  assign oRDY      = (r_state == IDLE);
  assign oDONE     = r_done;

endmodule

// File: tb/tb_fht_addr_seq.sv
// Bench for fht_addr_seq: BF_LAT=2 and BF_LAT=0 instances checked against a timeline model.
module tb_fht_addr_seq;

`ifdef FHT_STEP_EN
  localparam bit STEP_MODE = 1'b1;
  localparam int EXP_N0 = 44;
  localparam int EXP_N1 = 36;
`else
  localparam bit STEP_MODE = 1'b0;
  localparam int EXP_N0 = 41;
  localparam int EXP_N1 = 33;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  start;
  logic [11:0] rd   [2];
  logic [11:0] wr   [2];
  logic [2:0]  coef [2];
  logic [1:0]  stg  [2];
  logic        rdv  [2];
  logic        wea  [2];
  logic        web  [2];
  logic        stz  [2];
  logic        stl  [2];
  logic        rdy  [2];
  logic        done [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fht_addr_seq #(.A_BIT(3), .N_BANK(4), .BF_LAT(2)) u_dut0 (
    .iCLK(clk), .iRESET(rst), .iSTART(start[0]),
    .oADDR_RD(rd[0]), .oRD_VALID(rdv[0]), .oADDR_WR(wr[0]), .oADDR_COEF(coef[0]),
    .oWE_A(wea[0]), .oWE_B(web[0]), .oSTAGE(stg[0]), .oST_ZERO(stz[0]), .oST_LAST(stl[0]),
    .oRDY(rdy[0]), .oDONE(done[0])
  );

  fht_addr_seq #(.A_BIT(3), .N_BANK(4), .BF_LAT(0)) u_dut1 (
    .iCLK(clk), .iRESET(rst), .iSTART(start[1]),
    .oADDR_RD(rd[1]), .oRD_VALID(rdv[1]), .oADDR_WR(wr[1]), .oADDR_COEF(coef[1]),
    .oWE_A(wea[1]), .oWE_B(web[1]), .oSTAGE(stg[1]), .oST_ZERO(stz[1]), .oST_LAST(stl[1]),
    .oRDY(rdy[1]), .oDONE(done[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Read address bus for stage s, counter c: bank b in bits [3b+2:3b].
  function automatic logic [11:0] exp_rd(input int s, input int c);
    logic [11:0] v;
    int a;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      if (s == 0) a = ((c & 1) << 2) | (c & 2) | ((c >> 2) & 1);
      else        a = c ^ ((b & 1) << (s - 1));
      v[b*3 +: 3] = 3'(a);
    end
    return v;
  endfunction

  function automatic logic [2:0] exp_coef(input int s, input int c);
    if (s == 0) return 3'd0;
    return 3'(((c & ((1 << (s - 1)) - 1)) << (4 - s)) & 7);
  endfunction

  // Model: elapsed active cycles since start; stage and position follow from the period.
  bit m_active [2];
  bit m_paused [2];
  bit m_done   [2];
  int m_t      [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (rst) begin
        m_active[k] = 1'b0;
        m_paused[k] = 1'b0;
        m_t[k]      = 0;
      end else if (!m_active[k]) begin
        if (start[k]) begin
          m_active[k] = 1'b1;
          m_paused[k] = 1'b0;
          m_t[k]      = 0;
        end
      end else if (m_paused[k]) begin
        if (start[k]) m_paused[k] = 1'b0;
      end else begin
        m_t[k]++;
        if (m_t[k] % (8 + lat_of(k)) == 0) begin
          if (m_t[k] == 4 * (8 + lat_of(k))) begin
            m_active[k] = 1'b0;
            m_done[k]   = 1'b1;
            m_t[k]      = 0;
          end else if (STEP_MODE) begin
            m_paused[k] = 1'b1;
          end
        end
      end
    end
  end

  int          c_per, c_s, c_pos, c_lat;
  bit          c_rv, c_wv;
  logic [11:0] c_er, c_ew;
  logic [2:0]  c_ec;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        c_lat = lat_of(k);
        c_per = 8 + c_lat;
        c_s   = m_active[k] ? m_t[k] / c_per : 0;
        c_pos = m_t[k] % c_per;
        c_rv  = m_active[k] && !m_paused[k] && (c_pos < 8);
        c_wv  = m_active[k] && !m_paused[k] && (c_pos >= c_lat);
        c_er  = c_rv ? exp_rd(c_s, c_pos) : 12'd0;
        c_ec  = c_rv ? exp_coef(c_s, c_pos) : 3'd0;
        c_ew  = c_wv ? exp_rd(c_s, c_pos - c_lat) : 12'd0;
        chk("rd_addr", k, 32'(rd[k]), 32'(c_er));
        chk("rd_valid", k, 32'(rdv[k]), 32'(c_rv));
        chk("coef", k, 32'(coef[k]), 32'(c_ec));
        chk("wr_addr", k, 32'(wr[k]), 32'(c_ew));
        chk("we_a", k, 32'(wea[k]), 32'(c_wv && (c_s % 2 == 0)));
        chk("we_b", k, 32'(web[k]), 32'(c_wv && (c_s % 2 == 1)));
        chk("stage", k, 32'(stg[k]), 32'(c_s));
        chk("st_zero", k, 32'(stz[k]), 32'(m_active[k] && c_s == 0));
        chk("st_last", k, 32'(stl[k]), 32'(m_active[k] && c_s == 3));
        chk("rdy", k, 32'(rdy[k]), 32'(!m_active[k]));
        chk("done", k, 32'(done[k]), 32'(m_done[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse both starts and resume any paused instance until both report done.
  task automatic run_all(output int n0, output int n1, output int p0, output int d0cnt);
    bit d0, d1;
    d0 = 1'b0; d1 = 1'b0; n0 = 0; n1 = 0; p0 = 0; d0cnt = 0;
    start = 2'b11;
    for (int i = 1; i <= 600 && !(d0 && d1); i++) begin
      tick();
      start = 2'b00;
      if (done[0]) d0cnt++;
      if (!d0 && done[0]) begin d0 = 1'b1; n0 = i; end
      if (!d1 && done[1]) begin d1 = 1'b1; n1 = i; end
      start = {m_paused[1] && !d1, m_paused[0] && !d0};
      if (start[0]) p0++;
    end
    chk("done_seen", 0, 32'(d0), 32'd1);
    chk("done_seen", 1, 32'(d1), 32'd1);
  endtask

  int n0, n1, p0, dc0;

  initial begin
    rst   = 1'b1;
    start = 2'b00;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_rdy", 0, 32'(rdy[0]), 32'd1);
    chk("rst_done", 0, 32'(done[0]), 32'd0);
    chk("rst_rd", 0, 32'(rd[0]), 32'd0);
    chk("rst_stage", 1, 32'(stg[1]), 32'd0);
    rst = 1'b0;
    tick();

    start = 2'b11;
    tick();
    start = 2'b00;
    chk("rdy_fall", 0, 32'(rdy[0]), 32'd0);
    chk("rdy_fall", 1, 32'(rdy[1]), 32'd0);
`ifndef FHT_STEP_EN
    tick();                                   // t=1: stage 0, cnt 1
    chk("s0c1_rd", 0, 32'(rd[0]), 32'h924);
    chk("s0c1_wea", 0, 32'(wea[0]), 32'd0);
    chk("lat0_wr", 1, 32'(wr[1]), 32'h924);
    chk("lat0_wea", 1, 32'(wea[1]), 32'd1);
    repeat (2) tick();                        // t=3
    chk("s0c1_wr", 0, 32'(wr[0]), 32'h924);
    chk("s0c1_wea", 0, 32'(wea[0]), 32'd1);
    chk("s0c1_web", 0, 32'(web[0]), 32'd0);
    repeat (5) tick();                        // t=8: no drain at BF_LAT=0
    chk("lat0_stage", 1, 32'(stg[1]), 32'd1);
    chk("lat0_rd", 1, 32'(rd[1]), 32'h208);
    chk("drain_rdv", 0, 32'(rdv[0]), 32'd0);
    repeat (4) tick();                        // t=12
    chk("s1_web", 0, 32'(web[0]), 32'd1);
    chk("s1_wea", 0, 32'(wea[0]), 32'd0);
    repeat (13) tick();                       // t=25: stage 2, cnt 5
    chk("s2c5_rd", 0, 32'(rd[0]), 32'hF7D);
    chk("s2c5_coef", 0, 32'(coef[0]), 32'd4);
    repeat (2) tick();                        // t=27
    chk("s2c5_wr", 0, 32'(wr[0]), 32'hF7D);
    chk("s2c5_wea", 0, 32'(wea[0]), 32'd1);
    repeat (5) tick();                        // t=32
    chk("lat0_done", 1, 32'(done[1]), 32'd1);
    chk("early_done", 0, 32'(done[0]), 32'd0);
    repeat (8) tick();                        // t=40
    chk("end_done", 0, 32'(done[0]), 32'd1);
    chk("end_rdy", 0, 32'(rdy[0]), 32'd1);
    tick();
    chk("done_pulse", 0, 32'(done[0]), 32'd0);

    start = 2'b11;
    tick();
    start = 2'b00;
    repeat (5) tick();                        // t=5
    start = 2'b11;
    tick();                                   // t=6, start ignored
    start = 2'b00;
    chk("busy_start", 0, 32'(rd[0]), 32'h6DB);
    repeat (7) tick();                        // t=13: stage 1, cnt 3
    chk("s1c3_rd", 0, 32'(rd[0]), 32'h4D3);
    rst = 1'b1;
    tick();
    chk("midrst_rdy", 0, 32'(rdy[0]), 32'd1);
    chk("midrst_we", 0, 32'({wea[0], web[0]}), 32'd0);
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
`else
    repeat (10) tick();                       // stage 0 of inst0 complete
    chk("step_rdy", 0, 32'(rdy[0]), 32'd0);
    chk("step_stage", 0, 32'(stg[0]), 32'd1);
    repeat (3) tick();
    chk("step_hold", 0, 32'(rdv[0]), 32'd0);
    chk("step_hold_stage", 0, 32'(stg[0]), 32'd1);
    p0 = 0; dc0 = 0;
    for (int i = 0; i < 300 && m_active[0]; i++) begin
      start = {m_paused[1], m_paused[0]};
      if (start[0]) p0++;
      tick();
      start = 2'b00;
      if (done[0]) dc0++;
    end
    chk("step_resumes", 0, 32'(p0), 32'd3);
    chk("step_done_cnt", 0, 32'(dc0), 32'd1);
    rst = 1'b1;
    tick();
`endif
    start = 2'b11;
    tick();                                   // reset and start together
    chk("rst_wins", 0, 32'(rdy[0]), 32'd1);
    chk("rst_wins_rdv", 0, 32'(rdv[0]), 32'd0);
    rst   = 1'b0;
    start = 2'b00;
    tick();

    run_all(n0, n1, p0, dc0);
    chk("conv_len", 0, 32'(n0), 32'(EXP_N0));
    chk("conv_len", 1, 32'(n1), 32'(EXP_N1));
    chk("one_done", 0, 32'(dc0), 32'd1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
